wb_sel_pipe: RTL and testbench

Parametrised successor to the 4-input writeback-data mux. It selects one of N_SRC sources, applies load-style sign/zero extension, and forces x0 writes to zero. The result is registered behind a valid/ready handshake with a 2-entry skid buffer. It sits between the execute/memory stages and Write Data / Write Register of the register file.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_ext.sv | 25 ++
 rtl/wb_sel_pipe.sv | 141 ++++++++++++++
 tb/tb_wb_sel_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the writeback select pipeline: extension codes and
// the default destination-register index width.
package wb_pkg;

    // Load-style extension modes applied to the selected source.
    localparam logic [2:0] EXT_PASS = 3'b000;
    localparam logic [2:0] EXT_SB   = 3'b001;
    localparam logic [2:0] EXT_SH   = 3'b010;
    localparam logic [2:0] EXT_ZB   = 3'b011;
    localparam logic [2:0] EXT_ZH   = 3'b100;

    // Default register-file index width (32 architectural registers).
    localparam int unsigned WB_RD_W = 5;

endpackage

// File: rtl/wb_ext.sv
// Combinational load-style extender: sign/zero-extends the low byte or
// halfword of the input, or passes it through unchanged.
module wb_ext
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        ext,
    output logic [DATA_W-1:0] result
);

    // Decode the extension mode; reserved codes fall back to pass-through.
    always_comb begin
        result = data;
        case (ext)
            EXT_SB:  result = {{(DATA_W-8){data[7]}}, data[7:0]};
            EXT_SH:  result = {{(DATA_W-16){data[15]}}, data[15:0]};
            EXT_ZB:  result = {{(DATA_W-8){1'b0}}, data[7:0]};
            EXT_ZH:  result = {{(DATA_W-16){1'b0}}, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/wb_sel_pipe.sv
// Writeback data select pipeline: picks one of N_SRC sources, extends it,
// zeroes writes to x0 and registers the result behind a valid/ready
// handshake with a main register plus one skid register.
module wb_sel_pipe
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned RD_W   = WB_RD_W,
    localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [2:0]              ext,
    input  logic [RD_W-1:0]         rd,
    input  logic [N_SRC*DATA_W-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [RD_W-1:0]         out_rd,
    output logic                    out_err
);

    logic [DATA_W-1:0] src_sel;
    logic              sel_err;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] beat_data;

    logic accept;
    logic drain;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [RD_W-1:0]   main_rd_q,    main_rd_d;
    logic              main_err_q,   main_err_d;

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [RD_W-1:0]   skid_rd_q,    skid_rd_d;
    logic              skid_err_q,   skid_err_d;

    // Source select; an index with no matching source yields zero and flags an error.
    always_comb begin
        src_sel = '0;
        sel_err = 1'b1;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                src_sel = data_in[i*DATA_W +: DATA_W];
                sel_err = 1'b0;
            end
        end
    end

    wb_ext #(
        .DATA_W (DATA_W)
    ) u_ext (
        .data   (src_sel),
        .ext    (ext),
        .result (ext_data)
    );

    // x0 is hardwired to zero, so anything destined there is written as zero.
    assign beat_data = (rd == '0) ? '0 : ext_data;

    // in_ready depends only on the skid flop, keeping out_ready off the upstream path.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready;

    // Main/skid next state: refill main from skid first, then from the input;
    // park the input in skid only when main is stalled.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_rd_d    = main_rd_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_rd_d    = skid_rd_q;
        skid_err_d   = skid_err_q;

        if (flush) begin
            // Payload flops keep stale values; they are ignored while invalid.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_rd_d    = skid_rd_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = beat_data;
                main_rd_d    = rd;
                main_err_d   = sel_err;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = beat_data;
            skid_rd_d    = rd;
            skid_err_d   = sel_err;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_rd_q    <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_rd_q    <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_rd_q    <= main_rd_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_rd_q    <= skid_rd_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_rd    = main_rd_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Self-checking bench for wb_sel_pipe: vector table, hand-written handshake
// sequences, and a queue scoreboard checking every delivered beat.
module tb_wb_sel_pipe;
    import wb_pkg::*;

    localparam int unsigned DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic          err;
    } beat_t;

    typedef struct {
        logic [1:0]    sel;
        logic [2:0]    ext;
        logic [4:0]    rd;
        logic [DW-1:0] src;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid, in_ready;
    logic [1:0]    sel;
    logic [2:0]    ext;
    logic [4:0]    rd;
    logic [4*DW-1:0] data_in;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [4:0]    out_rd;
    logic          out_err;

    // Second instance with a non-power-of-two source count.
    logic          in_valid3, in_ready3, out_valid3, out_err3;
    logic [1:0]    sel3;
    logic [3*DW-1:0] data_in3;
    logic [DW-1:0] out_data3;
    logic [4:0]    out_rd3;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t cur_exp;
    beat_t mon_e;
    vec_t  vecs[10];
    bit    ok;
    bit    stop_rnd;
    time   t0;

    always #5 clk = ~clk;

    wb_sel_pipe #(.DATA_W(DW), .N_SRC(4), .RD_W(5)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .ext       (ext),
        .rd        (rd),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_err   (out_err)
    );

    wb_sel_pipe #(.DATA_W(DW), .N_SRC(3), .RD_W(5)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .ext       (ext),
        .rd        (rd),
        .data_in   (data_in3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .out_rd    (out_rd3),
        .out_err   (out_err3)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Sources filled with distinct background values, one slot overridden.
    function automatic logic [4*DW-1:0] mk(input int idx, input logic [DW-1:0] v);
        logic [4*DW-1:0] d;
        d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        d[idx*DW +: DW] = v;
        return d;
    endfunction

    // Scoreboard: pop on transfer, drop everything on flush, push on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got data=%h rd=%0d err=%0b", out_data, out_rd,
                             out_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e.data || out_rd !== mon_e.rd || out_err !== mon_e.err)
                    begin
                        errors++;
                        $display("FAIL beat got data=%h rd=%0d err=%0b want data=%h rd=%0d err=%0b",
                                 out_data, out_rd, out_err, mon_e.data, mon_e.rd, mon_e.err);
                    end
                end
            end
            if (flush) exp_q.delete();
            if (in_valid && in_ready && !flush) exp_q.push_back(cur_exp);
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [1:0] s, input logic [2:0] e, input logic [4:0] r,
                        input logic [4*DW-1:0] d, input logic [DW-1:0] ed, input logic ee,
                        output bit acc);
        sel      = s;
        ext      = e;
        rd       = r;
        data_in  = d;
        cur_exp  = '{data: ed, rd: r, err: ee};
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout got=not_accepted want=accepted data=%h", ed);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((out_valid || exp_q.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{sel: 2'd0, ext: EXT_PASS, rd: 5'd5, src: 32'hABCDEF17, exp: 32'hABCDEF17};
        vecs[1] = '{sel: 2'd2, ext: EXT_SB,   rd: 5'd1, src: 32'h000083FF, exp: 32'hFFFFFFFF};
        vecs[2] = '{sel: 2'd2, ext: EXT_ZB,   rd: 5'd1, src: 32'h000083FF, exp: 32'h000000FF};
        vecs[3] = '{sel: 2'd2, ext: EXT_SH,   rd: 5'd1, src: 32'h000083FF, exp: 32'hFFFF83FF};
        vecs[4] = '{sel: 2'd2, ext: EXT_ZH,   rd: 5'd1, src: 32'h000083FF, exp: 32'h000083FF};
        vecs[5] = '{sel: 2'd2, ext: 3'b111,   rd: 5'd1, src: 32'h000083FF, exp: 32'h000083FF};
        vecs[6] = '{sel: 2'd2, ext: 3'b101,   rd: 5'd2, src: 32'h000083FF, exp: 32'h000083FF};
        vecs[7] = '{sel: 2'd3, ext: EXT_PASS, rd: 5'd0, src: 32'h12345678, exp: 32'h00000000};
        vecs[8] = '{sel: 2'd1, ext: EXT_SB,   rd: 5'd7, src: 32'hFFFFFF7F, exp: 32'h0000007F};
        vecs[9] = '{sel: 2'd3, ext: EXT_SH,   rd: 5'd31, src: 32'h00017FFF, exp: 32'h00007FFF};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel = '0; ext = EXT_PASS; rd = '0; data_in = '0;
        in_valid3 = 1'b0; sel3 = '0; data_in3 = '0;
        cur_exp = '{data: '0, rd: '0, err: 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table with 1-cycle latency check on each beat
        foreach (vecs[i]) begin
            send(vecs[i].sel, vecs[i].ext, vecs[i].rd, mk(int'(vecs[i].sel), vecs[i].src),
                 vecs[i].exp, 1'b0, ok);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
        end
        drain();

        // Throughput: back-to-back beats with out_ready high
        t0 = $time;
        for (int i = 0; i < 6; i++) begin
            send(2'(i % 4), EXT_PASS, 5'(i + 10), mk(i % 4, 32'(i + 500)), 32'(i + 500), 1'b0, ok);
        end
        chk("throughput_cycles", 32'(($time - t0) / 10), 32'd6);
        drain();

        // Backpressure: A in main, B in skid, C held until out_ready rises
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(2'd0, EXT_PASS, 5'd2, mk(0, 32'd1), 32'd1, 1'b0, ok);
        chk("bp_ready_after_a", 32'(in_ready), 32'd1);
        send(2'd0, EXT_PASS, 5'd2, mk(0, 32'd2), 32'd2, 1'b0, ok);
        chk("bp_ready_after_b", 32'(in_ready), 32'd0);
        fork
            send(2'd0, EXT_PASS, 5'd3, mk(0, 32'd3), 32'd3, 1'b0, ok);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_hold_ready", 32'(in_ready), 32'd0);
                    chk("bp_hold_data", out_data, 32'd1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("bp_no_gap_valid", 32'(out_valid), 32'd1);
        chk("bp_no_gap_data", out_data, 32'd3);
        drain();

        // Random out_ready: no beat lost or duplicated
        stop_rnd = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send(2'(i % 4), EXT_PASS, 5'(i + 1), mk(i % 4, 32'(i * 7 + 100)),
                         32'(i * 7 + 100), 1'b0, ok);
                end
                stop_rnd = 1'b1;
            end
            begin
                while (!stop_rnd) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Flush with main and skid full plus a same-cycle beat
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(2'd0, EXT_PASS, 5'd6, mk(0, 32'h11), 32'h11, 1'b0, ok);
        send(2'd0, EXT_PASS, 5'd6, mk(0, 32'h22), 32'h22, 1'b0, ok);
        sel = 2'd0; ext = EXT_PASS; rd = 5'd6; data_in = mk(0, 32'hDEAD);
        cur_exp = '{data: 32'hDEAD, rd: 5'd6, err: 1'b0};
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_stays_empty", 32'(out_valid), 32'd0);
        end
        drain();

        // Flush coinciding with a transfer and an input beat
        send(2'd1, EXT_PASS, 5'd8, mk(1, 32'h33), 32'h33, 1'b0, ok);
        sel = 2'd0; data_in = mk(0, 32'hBEEF); in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_xfer_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Out-of-range select on the three-source instance
        rd = 5'd4; ext = EXT_PASS; sel3 = 2'd3;
        data_in3 = {32'h33333333, 32'h22222222, 32'h11111111};
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        chk("n3_range_valid", 32'(out_valid3), 32'd1);
        chk("n3_range_data", out_data3, 32'd0);
        chk("n3_range_err", 32'(out_err3), 32'd1);
        sel3 = 2'd2;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        chk("n3_sel2_data", out_data3, 32'h33333333);
        chk("n3_sel2_err", 32'(out_err3), 32'd0);
        chk("n3_sel2_rd", 32'(out_rd3), 32'd4);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(2'd0, EXT_PASS, 5'd9, mk(0, 32'h5A5A), 32'h5A5A, 1'b0, ok);
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_rd", 32'(out_rd), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sel = 2'd0; ext = EXT_PASS; rd = 5'd4; data_in = mk(0, 32'h77);
        cur_exp = '{data: 32'h77, rd: 5'd4, err: 1'b0};
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(cur_exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("arst_first_accept_valid", 32'(out_valid), 32'd1);
        chk("arst_first_accept_data", out_data, 32'h77);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
